// File: rtl/emin_pkg.sv
// Shared types and width helpers for the E-min result scheduler.
package emin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_COLLECT,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a flat row-major address into an n x n matrix.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n * n) : 1;
  endfunction

  localparam int unsigned DEF_I      = 160;
  localparam int unsigned DEF_ADDR_W = addr_w(DEF_I);

endpackage

// File: rtl/emin_sched.sv
// Row-sweep scheduler: launches the E-min engine per row and writes results into the E buffer.
// Optional per-result watchdog enabled by defining EMIN_SCHED_TIMEOUT_EN.
module emin_sched
  import emin_pkg::*;
#(
  parameter int unsigned I           = 160,
  parameter int unsigned BIT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  output logic [idx_w(I)-1:0]     emin_i_out,
  output logic                    emin_valid_out,
  input  logic [idx_w(I)-1:0]     emin_j_in,
  input  logic [BIT_WIDTH-1:0]    emin_data_in,
  input  logic                    emin_valid_in,
  output logic [addr_w(I)-1:0]    e_addr_out,
  output logic [BIT_WIDTH-1:0]    e_data_out,
  output logic                    e_we_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    seq_err_out,
  output logic                    timeout_out
);

  localparam int unsigned IW = idx_w(I);
  localparam int unsigned AW = addr_w(I);

  state_e              state_q, state_d;
  logic [IW-1:0]       i_q, i_d;
  logic [IW-1:0]       expj_q, expj_d;
  logic [AW-1:0]       base_q, base_d;
  logic                seq_err_q, seq_err_d;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [BIT_WIDTH-1:0] data_q;

  logic take;
  logic start_acc;
  logic timeout_hit;

  assign take      = (state_q == ST_COLLECT) && emin_valid_in;
  assign start_acc = (state_q == ST_IDLE) && start_in && !abort_in;

`ifdef EMIN_SCHED_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wd_q, wd_d;
  logic          timeout_q;

  // Counts idle COLLECT cycles since launch or the most recent result.
  always_comb begin
    wd_d        = '0;
    timeout_hit = 1'b0;
    if (state_q == ST_COLLECT && !emin_valid_in) begin
      wd_d = wd_q + WW'(1);
      if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
        timeout_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (start_acc) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_out = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_out = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    base_d    = base_q;
    expj_d    = expj_q;
    seq_err_d = seq_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d   = ST_LAUNCH;
          i_d       = '0;
          base_d    = '0;
          expj_d    = '0;
          seq_err_d = 1'b0;
        end
      end
      ST_LAUNCH: state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (emin_valid_in) begin
          if (emin_j_in != expj_q) begin
            seq_err_d = 1'b1;
          end
          expj_d = expj_q + IW'(1);
          // Row completion is by result count, so out-of-order j still yields i+1 writes.
          if (expj_q == i_q) begin
            state_d = (i_q == IW'(I - 1)) ? ST_DONE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_LAUNCH;
        i_d     = i_q + IW'(1);
        base_d  = base_q + AW'(I);
        expj_d  = '0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_in || timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      base_q    <= '0;
      expj_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      base_q    <= base_d;
      expj_q    <= expj_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Capture stage is independent of abort so an accepted result is always written.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= take;
      if (take) begin
        addr_q <= base_q + AW'(emin_j_in);
        data_q <= emin_data_in;
      end
    end
  end

  assign emin_i_out     = i_q;
  assign emin_valid_out = (state_q == ST_LAUNCH);
  assign e_addr_out     = addr_q;
  assign e_data_out     = data_q;
  assign e_we_out       = we_q;
  assign busy_out       = (state_q != ST_IDLE);
  assign done_out       = (state_q == ST_DONE);
  assign seq_err_out    = seq_err_q;

endmodule
